// File: rtl/capture_engine.sv
// rtl/capture_engine.sv - capture controller: pre-trigger fill, trigger evaluation, post-trigger count.
// Drives sample RAM write enable/address and reports armed/triggered/done status.
module capture_engine #(
  parameter int NUM_CH  = 5,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt_smpl,
  input  logic              run,
  input  logic              abort,
  input  logic [LOG2-1:0]   trig_pos,
  input  logic [NUM_CH-1:0] chan_trig,
  input  logic [NUM_CH-1:0] trig_en,
  input  logic              prot_trig,
  input  logic              prot_en,
  input  logic              trig_and,
  input  logic              auto_rearm,
  input  logic              clr_capture_done,
  output logic              we,
  output logic [LOG2-1:0]   waddr,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done,
  output logic [LOG2-1:0]   trig_addr
);

  typedef enum logic [2:0] {S_IDLE, S_PRETRIG, S_ARMED, S_POSTTRIG, S_DONE} state_t;

  localparam int CW = LOG2 + 1;
  localparam logic [CW-1:0]   ENT  = CW'(ENTRIES);
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  state_t          state_q, state_d;
  logic [LOG2-1:0] waddr_q, waddr_d, trig_addr_q, trig_addr_d, waddr_inc;
  logic [CW-1:0]   pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic [CW-1:0]   eff_post, pre_need, pre_inc, post_inc;
  logic            any_en, or_hit, and_hit, hit;

  always_comb begin
    if (trig_pos == '0)
      eff_post = CW'(1);
    else if ({1'b0, trig_pos} > ENT - CW'(1))
      eff_post = ENT - CW'(1);
    else
      eff_post = {1'b0, trig_pos};
  end

  assign pre_need = ENT - eff_post;
  assign pre_inc  = pre_cnt_q + CW'(1);
  assign post_inc = post_cnt_q + CW'(1);

  // With no source enabled the AND reduction would be vacuously true; any_en blocks that.
  assign any_en  = (|trig_en) | prot_en;
  assign or_hit  = (|(chan_trig & trig_en)) | (prot_trig & prot_en);
  assign and_hit = any_en & (&(chan_trig | ~trig_en)) & (prot_trig | ~prot_en);
  assign hit     = trig_and ? and_hit : or_hit;

  assign we = wrt_smpl & ((state_q == S_PRETRIG) | (state_q == S_ARMED) | (state_q == S_POSTTRIG));
  assign waddr_inc = (waddr_q == LAST) ? '0 : waddr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (run) begin
          state_d    = S_PRETRIG;
          waddr_d    = '0;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
        end
        S_PRETRIG: if (we) begin
          waddr_d   = waddr_inc;
          pre_cnt_d = pre_inc;
          if (pre_inc == pre_need) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (we) waddr_d = waddr_inc;
          // trig_addr points at the first sample written after the hit
          if (hit) begin
            state_d     = S_POSTTRIG;
            post_cnt_d  = '0;
            trig_addr_d = we ? waddr_inc : waddr_q;
          end
        end
        S_POSTTRIG: if (we) begin
          waddr_d    = waddr_inc;
          post_cnt_d = post_inc;
          if (post_inc == eff_post) state_d = S_DONE;
        end
        S_DONE: if (clr_capture_done) begin
          if (auto_rearm) begin
            state_d    = S_PRETRIG;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
    end
  end

  assign waddr        = waddr_q;
  assign trig_addr    = trig_addr_q;
  assign armed        = (state_q == S_ARMED);
  assign triggered    = (state_q == S_POSTTRIG) | (state_q == S_DONE);
  assign capture_done = (state_q == S_DONE);

endmodule

// File: tb/tb_capture_engine.sv
// tb/tb_capture_engine.sv - directed/table-driven bench for capture_engine (ENTRIES=16, LOG2=4, NUM_CH=5).
module tb_capture_engine;

  logic       clk = 1'b0;
  logic       rst_n, wrt_smpl, run, abort, prot_trig, prot_en, trig_and, auto_rearm, clr_capture_done;
  logic [3:0] trig_pos;
  logic [4:0] chan_trig, trig_en;
  logic       we, armed, triggered, capture_done;
  logic [3:0] waddr, trig_addr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] chan;
    logic [4:0] en;
    logic       prot;
    logic       pen;
    logic       andm;
    logic       exp;
  } vec_t;
  vec_t tbl[9];

  capture_engine #(.NUM_CH(5), .ENTRIES(16), .LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .run(run), .abort(abort),
    .trig_pos(trig_pos), .chan_trig(chan_trig), .trig_en(trig_en),
    .prot_trig(prot_trig), .prot_en(prot_en), .trig_and(trig_and),
    .auto_rearm(auto_rearm), .clr_capture_done(clr_capture_done),
    .we(we), .waddr(waddr), .armed(armed), .triggered(triggered),
    .capture_done(capture_done), .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic status0(input string tag);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_triggered"}, triggered, 0);
    chk({tag, "_done"}, capture_done, 0);
    chk({tag, "_we"}, we, 0);
  endtask

  // Abort to IDLE, start with trig_pos=4 and fill 12 samples; ends in ARMED at waddr=12.
  task automatic arm();
    wrt_smpl = 0; abort = 1; step(); abort = 0;
    trig_en = '0; prot_en = 0; chan_trig = '0; prot_trig = 0; trig_pos = 4;
    run = 1; step(); run = 0;
    wrt_smpl = 1;
    repeat (12) step();
    wrt_smpl = 0;
    chk("arm_armed", armed, 1);
    chk("arm_waddr", waddr, 12);
  endtask

  initial begin
    int exp_w;
    tbl[0] = '{chan: 5'b00001, en: 5'b00001, prot: 0, pen: 0, andm: 0, exp: 1};
    tbl[1] = '{chan: 5'b11110, en: 5'b00001, prot: 1, pen: 0, andm: 0, exp: 0};
    tbl[2] = '{chan: 5'b00000, en: 5'b00000, prot: 1, pen: 1, andm: 0, exp: 1};
    tbl[3] = '{chan: 5'b11111, en: 5'b00000, prot: 1, pen: 0, andm: 0, exp: 0};
    tbl[4] = '{chan: 5'b00101, en: 5'b00101, prot: 0, pen: 1, andm: 1, exp: 0};
    tbl[5] = '{chan: 5'b00101, en: 5'b00101, prot: 1, pen: 1, andm: 1, exp: 1};
    tbl[6] = '{chan: 5'b00100, en: 5'b00101, prot: 1, pen: 1, andm: 1, exp: 0};
    tbl[7] = '{chan: 5'b11111, en: 5'b00000, prot: 1, pen: 0, andm: 1, exp: 0};
    tbl[8] = '{chan: 5'b10000, en: 5'b10000, prot: 0, pen: 0, andm: 1, exp: 1};

    rst_n = 0; wrt_smpl = 1; run = 0; abort = 0; prot_trig = 0; prot_en = 0; trig_and = 0;
    auto_rearm = 0; clr_capture_done = 0; trig_pos = 4; chan_trig = '0; trig_en = '0;
    #12;
    status0("reset");
    chk("reset_waddr", waddr, 0);
    chk("reset_trig_addr", trig_addr, 0);
    @(posedge clk); #1; rst_n = 1; wrt_smpl = 0;

    // Single capture, trigger held high through PRETRIG
    trig_en = 5'b00001;
    run = 1; step(); run = 0;
    chk("run_waddr", waddr, 0);
    wrt_smpl = 1; chan_trig = 5'b00001; #1;
    chk("we_pretrig", we, 1);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("pre_triggered", triggered, 0);
      chk("pre_armed", armed, (i == 12) ? 1 : 0);
    end
    chk("armed_waddr", waddr, 12);
    step();
    chk("early_trig_triggered", triggered, 1);
    chk("early_trig_armed", armed, 0);
    chk("early_trig_addr", trig_addr, 13);
    chan_trig = '0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("post_done", capture_done, (i == 4) ? 1 : 0);
    end
    chk("done_waddr", waddr, 1);
    chk("done_we", we, 0);
    run = 1; chan_trig = 5'b00001; step(); run = 0; chan_trig = '0;
    chk("done_hold", capture_done, 1);
    chk("done_waddr_frozen", waddr, 1);
    chk("done_trig_addr_frozen", trig_addr, 13);

    // Auto rearm keeps waddr
    auto_rearm = 1; clr_capture_done = 1; step(); clr_capture_done = 0;
    chk("rearm_done", capture_done, 0);
    chk("rearm_triggered", triggered, 0);
    chk("rearm_waddr", waddr, 1);
    repeat (11) step();
    chk("rearm_not_yet", armed, 0);
    step();
    chk("rearm_armed", armed, 1);
    chk("rearm_armed_waddr", waddr, 13);
    wrt_smpl = 0; chan_trig = 5'b00001; step(); chan_trig = '0;
    chk("nowrite_trig_addr", trig_addr, 13);
    wrt_smpl = 1; repeat (4) step();
    chk("rearm_cap_done", capture_done, 1);
    chk("rearm_cap_waddr", waddr, 1);

    // No rearm -> IDLE
    wrt_smpl = 0; auto_rearm = 0; clr_capture_done = 1; step(); clr_capture_done = 0;
    status0("idle");
    chk("idle_waddr", waddr, 1);

    // Clamp trig_pos=0 -> eff_post=1, pre_need=15; wrap during long ARMED
    trig_pos = 0; run = 1; step(); run = 0;
    chk("restart_waddr", waddr, 0);
    wrt_smpl = 1; repeat (15) step();
    chk("clamp_armed", armed, 1);
    exp_w = 15;
    for (int i = 0; i < 40; i++) begin
      step();
      exp_w = (exp_w + 1) % 16;
      chk("wrap_waddr", waddr, exp_w);
    end
    chk("wrap_still_armed", armed, 1);
    chan_trig = 5'b00001; step(); chan_trig = '0;
    chk("clamp_trig_addr", trig_addr, 8);
    chk("clamp_triggered", triggered, 1);
    step();
    chk("clamp_done", capture_done, 1);
    chk("clamp_waddr", waddr, 9);
    wrt_smpl = 0;

    // Trigger combination table
    for (int v = 0; v < 9; v++) begin
      arm();
      chan_trig = tbl[v].chan; trig_en = tbl[v].en; prot_trig = tbl[v].prot;
      prot_en = tbl[v].pen; trig_and = tbl[v].andm;
      step();
      chk($sformatf("tbl%0d_triggered", v), triggered, tbl[v].exp);
      chk($sformatf("tbl%0d_armed", v), armed, !tbl[v].exp);
    end
    trig_and = 0;

    // Abort mid-POSTTRIG
    arm();
    trig_en = 5'b00001; chan_trig = 5'b00001; step(); chan_trig = '0;
    chk("abort_trig_addr", trig_addr, 12);
    wrt_smpl = 1; repeat (2) step();
    chk("abort_pre_triggered", triggered, 1);
    abort = 1; step(); abort = 0;
    status0("abort");
    chk("abort_waddr", waddr, 14);
    chk("abort_trig_addr_held", trig_addr, 12);

    // Async reset mid-capture
    arm();
    wrt_smpl = 1; repeat (3) step();
    #2; rst_n = 0; #1;
    status0("async_rst");
    chk("async_rst_waddr", waddr, 0);
    chk("async_rst_trig_addr", trig_addr, 0);
    #10; rst_n = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/capture_engine.md
Name: capture_engine

Overview:
Parametrised capture controller for the logic analyzer digital core. It generalises the fixed five-channel trigger/capture path to NUM_CH channels, a configurable RAM depth, AND/OR trigger combination and optional auto-rearm. It sits between the per-channel trigger detectors and the protocol trigger on one side, and the shared channel sample RAMs and cmd_cfg on the other. It drives RAM write enable and address, and reports armed, triggered and capture-done status.

Parameters:
NUM_CH, 5, number of channel trigger inputs (1..16)
ENTRIES, 384, RAM depth in samples (12288 on DE-0)
LOG2, 9, address width; ENTRIES <= 2**LOG2

Ports:
clk  input  1  100MHz system clock
rst_n  input  1  asynchronous active-low reset
wrt_smpl  input  1  sample-write strobe from the decimation logic
run  input  1  start capture pulse from cmd_cfg
abort  input  1  cancel capture; returns to IDLE
trig_pos  input  LOG2  number of post-trigger samples to keep
chan_trig  input  NUM_CH  per-channel trigger hits
trig_en  input  NUM_CH  per-channel trigger enables
prot_trig  input  1  protocol trigger hit
prot_en  input  1  protocol trigger enable
trig_and  input  1  1 = AND of enabled sources, 0 = OR
auto_rearm  input  1  restart capture after the done status is cleared
clr_capture_done  input  1  host has finished readout
we  output  1  RAM write enable
waddr  output  LOG2  RAM write address
armed  output  1  pre-trigger fill is complete; trigger is being evaluated
triggered  output  1  trigger has occurred in this capture
capture_done  output  1  buffer is full and frozen
trig_addr  output  LOG2  address of the first post-trigger sample

Behaviour:
- Reset (async): state=IDLE; waddr, trig_addr and both counters = 0; all status outputs = 0.
- States: IDLE, PRETRIG, ARMED, POSTTRIG, DONE.
- Status outputs are state decodes:
  - armed = ARMED
  - triggered = POSTTRIG or DONE
  - capture_done = DONE
- we = wrt_smpl & state in {PRETRIG, ARMED, POSTTRIG}. This is combinational, with 0 latency from wrt_smpl.
- Every write increments waddr on the next clk edge. waddr wraps from ENTRIES-1 to 0.
- eff_post = trig_pos clamped to the range 1..ENTRIES-1. pre_need = ENTRIES - eff_post.
- IDLE: run -> PRETRIG. waddr, pre_cnt and post_cnt are cleared on that transition.
- PRETRIG:
  - Each write increments pre_cnt.
  - On the write that makes pre_cnt == pre_need, go to ARMED.
  - Triggers are ignored in this state.
- ARMED:
  - Writes continue as a circular overwrite.
  - Trigger hit, evaluated every clk:
    - OR mode: |(chan_trig & trig_en) | (prot_trig & prot_en)
    - AND mode: &(chan_trig | ~trig_en) & (prot_trig | ~prot_en)
  - If no enable bit is set, the trigger never fires in either mode.
  - On a hit, go to POSTTRIG, clear post_cnt, and load trig_addr with the next waddr value.
  - If wrt_smpl coincides with the hit, that sample is the last pre-trigger sample, and trig_addr = waddr+1 (wrapped).
- POSTTRIG:
  - Each write increments post_cnt.
  - On the write that makes post_cnt == eff_post, go to DONE.
  - At exit, waddr equals the oldest sample address, which is trig_addr + eff_post (mod ENTRIES).
- DONE:
  - we = 0; waddr and trig_addr are frozen; the trigger is ignored.
  - clr_capture_done -> PRETRIG if auto_rearm is 1 (counters cleared, waddr kept); otherwise -> IDLE.
- abort in any state -> IDLE on the next clk. waddr and trig_addr are held; status outputs drop to 0.
- Priority: abort > clr_capture_done > run. run outside IDLE is ignored.
- trig_pos and mode inputs are sampled live. Changing them while not in IDLE is not supported; the result is defined only by the clamp rule.
- Counter widths are LOG2+1 bits, so they cannot overflow at ENTRIES = 2**LOG2.

Test Plan:
All scenarios use ENTRIES=16, LOG2=4, NUM_CH=5.
- Single capture: trig_pos=4, OR mode, trig_en=00001. run, then wrt_smpl every clk.
  -> armed after 12 writes (waddr=12).
  -> chan_trig[0] pulse gives triggered=1 next clk, trig_addr = next waddr.
  -> after 4 more writes, capture_done=1, we=0, waddr = trig_addr+4 mod 16.
- Early trigger: chan_trig[0] held high during PRETRIG.
  -> no transition until armed.
  -> trigger fires on the first ARMED clk.
- AND mode: trig_en=00101, prot_en=1.
  -> ch0 and ch2 high with prot low: no trigger.
  -> all three high: triggered=1 next clk.
  -> trig_en=0 and prot_en=0: never triggers.
- Wrap and clamp: hold ARMED for 40 writes.
  -> waddr runs 15->0 repeatedly.
  -> trig_pos=0 behaves as 1: DONE one write after the trigger.
- Rearm: in DONE, clr_capture_done with auto_rearm=1.
  -> PRETRIG; armed again after 12 new writes.
  -> with auto_rearm=0: IDLE, all status 0, and a later run restarts at waddr=0.
- Abort/reset: abort mid-POSTTRIG -> IDLE next clk, we=0, status 0. rst_n low mid-capture -> all outputs 0 immediately, with no clk required.
